// File: rtl/array_shift_pack.sv
// array_shift_pack
//   Packs a stream of NIB_W-bit fields into WORD_W-bit words. The field
//   accepted into slot k lands at XOUT[NIB_W*k +: NIB_W]. This is the inverse
//   of shift-and-slice extraction. A word closes when its last slot is filled
//   or when IN_LAST is set. The closed word is then held in XOUT until the
//   consumer takes it. While a word is held, a new field may be accepted in
//   the same cycle as the handshake, so the input never sees a bubble.
//
// Ports
//   CLK        clock, rising edge
//   RST_N      synchronous active-low reset
//   DIN        field to insert (NIB_W bits)
//   IN_VALID   DIN / IN_LAST valid
//   IN_LAST    current field closes the word early
//   IN_READY   block accepts a field this cycle
//   XOUT       assembled word (WORD_W bits)
//   OUT_COUNT  number of valid fields in XOUT (1..NSLOT)
//   OUT_VALID  XOUT / OUT_COUNT valid
//   OUT_READY  consumer accepts XOUT this cycle
module array_shift_pack #(
  parameter int WORD_W = 32,
  parameter int NIB_W  = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NIB_W-1:0]  DIN,
  input  logic              IN_VALID,
  input  logic              IN_LAST,
  output logic              IN_READY,
  output logic [WORD_W-1:0] XOUT,
  output logic [3:0]        OUT_COUNT,
  output logic              OUT_VALID,
  input  logic              OUT_READY
);

  localparam int NSLOT = WORD_W / NIB_W;
  localparam int PTR_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NSLOT - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [WORD_W-1:0]  acc_q, acc_d;
  logic [WORD_W-1:0]  xout_q, xout_d;
  logic [3:0]         cnt_q, cnt_d;

  logic               in_ready;
  logic               in_fire;
  logic               word_close;
  logic [WORD_W-1:0]  ins_word;

  // While a word is held, the input may only advance when the consumer takes
  // the held word in the same cycle. That slot-0 write starts the next word.
  assign in_ready  = (state_q == FILL) || OUT_READY;
  assign in_fire   = IN_VALID && in_ready;
  assign IN_READY  = in_ready;
  assign OUT_VALID = (state_q == HOLD);
  assign XOUT      = xout_q;
  assign OUT_COUNT = cnt_q;

  // ACC with the incoming field placed in slot PTR. Slots that have not been
  // written are still zero, so an early close leaves them reading zero. In
  // HOLD, ACC is zero and PTR is 0, so this same word is the slot-0 restart.
  always_comb begin
    ins_word = acc_q;
    for (int k = 0; k < NSLOT; k++) begin
      if (ptr_q == PTR_W'(k)) begin
        ins_word[k*NIB_W +: NIB_W] = DIN;
      end
    end
  end

  assign word_close = (ptr_q == LAST_PTR) || IN_LAST;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    acc_d   = acc_q;
    xout_d  = xout_q;
    cnt_d   = cnt_q;

    // The held word is taken: fall back to FILL unless a new word closes.
    if (state_q == HOLD && OUT_READY) begin
      state_d = FILL;
    end

    if (in_fire) begin
      if (word_close) begin
        xout_d  = ins_word;
        cnt_d   = 4'(ptr_q) + 4'd1;
        acc_d   = '0;
        ptr_d   = '0;
        state_d = HOLD;
      end else begin
        acc_d   = ins_word;
        ptr_d   = ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= FILL;
      ptr_q   <= '0;
      acc_q   <= '0;
      xout_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      acc_q   <= acc_d;
      xout_q  <= xout_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_array_shift_pack.sv
module tb_array_shift_pack;

  localparam int WORD_W = 32;
  localparam int NIB_W  = 4;
  localparam int NSLOT  = WORD_W / NIB_W;

  logic              CLK;
  logic              RST_N;
  logic [NIB_W-1:0]  DIN;
  logic              IN_VALID;
  logic              IN_LAST;
  logic              IN_READY;
  logic [WORD_W-1:0] XOUT;
  logic [3:0]        OUT_COUNT;
  logic              OUT_VALID;
  logic              OUT_READY;

  int checks = 0;
  int errors = 0;

  // Reference model: fields of the word in progress, plus the held word.
  logic [NIB_W-1:0]  cur[$];
  logic [NIB_W-1:0]  held_fields[$];
  logic              held_v;
  logic [WORD_W-1:0] m_xout;
  int                m_cnt;

  array_shift_pack #(.WORD_W(WORD_W), .NIB_W(NIB_W)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .DIN      (DIN),
    .IN_VALID (IN_VALID),
    .IN_LAST  (IN_LAST),
    .IN_READY (IN_READY),
    .XOUT     (XOUT),
    .OUT_COUNT(OUT_COUNT),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur.delete();
    held_fields.delete();
    held_v = 1'b0;
    m_xout = '0;
    m_cnt  = 0;
  endtask

  // Called at posedge+1. Drives inputs, checks outputs, then advances one edge.
  task automatic cycle(input logic [NIB_W-1:0] d, input logic v, input logic l,
                       input logic r);
    logic in_fire;
    logic out_fire;
    DIN = d; IN_VALID = v; IN_LAST = l; OUT_READY = r;
    #2;
    chk("in_ready", 32'(IN_READY), 32'(!held_v || r));
    chk("out_valid", 32'(OUT_VALID), 32'(held_v));
    if (held_v) begin
      chk("xout", XOUT, m_xout);
      chk("out_count", 32'(OUT_COUNT), 32'(m_cnt));
      for (int k = 0; k < NSLOT; k++) begin
        chk("slice", 32'((XOUT >> (NIB_W*k)) & 32'hF),
            (k < m_cnt) ? 32'(held_fields[k]) : 32'd0);
      end
    end
    @(posedge CLK);
    in_fire  = v && (!held_v || r);
    out_fire = held_v && r;
    if (out_fire) held_v = 1'b0;
    if (in_fire) begin
      cur.push_back(d);
      if (cur.size() == NSLOT || l) begin
        held_fields = cur;
        m_xout = '0;
        for (int k = 0; k < cur.size(); k++) m_xout |= WORD_W'(cur[k]) << (NIB_W*k);
        m_cnt  = cur.size();
        held_v = 1'b1;
        cur.delete();
      end
    end
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    DIN = NIB_W'($urandom); IN_VALID = 1'b1; IN_LAST = 1'b1; OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    model_reset();
    RST_N = 1'b1; IN_VALID = 1'b0; IN_LAST = 1'b0; OUT_READY = 1'b0;
    #1;
    chk("rst_xout", XOUT, 32'h0);
    chk("rst_count", 32'(OUT_COUNT), 32'd0);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_in_ready", 32'(IN_READY), 32'd1);
  endtask

  initial begin
    logic [NIB_W-1:0] d;
    logic [3:0]       bb[3];
    model_reset();
    RST_N = 1'b0; DIN = '0; IN_VALID = 1'b0; IN_LAST = 1'b0; OUT_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    do_reset();

    // Full word 1..8.
    for (int i = 1; i <= 8; i++) cycle(NIB_W'(i), 1'b1, 1'b0, 1'b1);
    chk("full_word", XOUT, 32'h87654321);
    chk("full_count", 32'(OUT_COUNT), 32'd8);
    chk("full_valid", 32'(OUT_VALID), 32'd1);
    cycle(4'h0, 1'b0, 1'b0, 1'b1);
    chk("full_valid_once", 32'(OUT_VALID), 32'd0);

    // Early close.
    cycle(4'hA, 1'b1, 1'b0, 1'b1);
    cycle(4'hB, 1'b1, 1'b1, 1'b1);
    chk("early_word", XOUT, 32'h000000BA);
    chk("early_count", 32'(OUT_COUNT), 32'd2);

    // Backpressure on the held BA word, then a no-bubble restart with 5.
    for (int i = 0; i < 5; i++) begin
      cycle(NIB_W'($urandom), 1'b1, 1'b0, 1'b0);
      chk("bp_stable", XOUT, 32'h000000BA);
    end
    cycle(4'h5, 1'b1, 1'b0, 1'b1);
    cycle(4'h6, 1'b1, 1'b1, 1'b1);
    chk("bp_next_word", XOUT, 32'h00000065);
    chk("bp_next_count", 32'(OUT_COUNT), 32'd2);

    // Back-to-back single-field words.
    bb[0] = 4'h3; bb[1] = 4'h7; bb[2] = 4'h9;
    for (int i = 0; i < 3; i++) begin
      cycle(bb[i], 1'b1, 1'b1, 1'b1);
      chk("b2b_word", XOUT, 32'(bb[i]));
      chk("b2b_count", 32'(OUT_COUNT), 32'd1);
      chk("b2b_valid", 32'(OUT_VALID), 32'd1);
    end
    cycle(4'h0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word discards the partial word.
    for (int i = 0; i < 3; i++) cycle(NIB_W'(i + 1), 1'b1, 1'b0, 1'b1);
    do_reset();
    cycle(4'hF, 1'b1, 1'b1, 1'b1);
    chk("rst_mid_word", XOUT, 32'h0000000F);
    chk("rst_mid_count", 32'(OUT_COUNT), 32'd1);

    // Reset while holding a word.
    cycle(4'h2, 1'b1, 1'b1, 1'b0);
    cycle(4'h0, 1'b0, 1'b0, 1'b0);
    do_reset();
    cycle(4'h0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        d = NIB_W'($urandom);
        cycle(d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) != 0));
      end
    end
    for (int i = 0; i < 4; i++) cycle(4'h0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/array_shift_pack.md
ARRAY_SHIFT_PACK -- requirements
Module: array_shift_pack

Interface
REQ-001 Parameter WORD_W, default 32, packed output word width in bits.
REQ-002 Parameter NIB_W, default 4, input field width in bits; WORD_W SHALL be an integer multiple of NIB_W; NSLOT = WORD_W/NIB_W (8 at defaults).
REQ-003 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 RST_N  input  1  reset, synchronous, active-low.
REQ-005 DIN  input  NIB_W  field to insert into the word under assembly.
REQ-006 IN_VALID  input  1  DIN/IN_LAST valid.
REQ-007 IN_LAST  input  1  current field closes the word early.
REQ-008 IN_READY  output  1  block accepts a field this cycle.
REQ-009 XOUT  output  WORD_W  assembled word.
REQ-010 OUT_COUNT  output  4  number of valid fields in XOUT, 1..NSLOT.
REQ-011 OUT_VALID  output  1  XOUT/OUT_COUNT valid.
REQ-012 OUT_READY  input  1  consumer accepts XOUT this cycle.

Function
REQ-013 Inverse of shift-and-slice extraction: field accepted into slot k SHALL occupy XOUT[NIB_W*k+NIB_W-1 : NIB_W*k], i.e. word |= DIN << (NIB_W*k); extracting (XOUT >> NIB_W*k)[NIB_W-1:0] returns it.
REQ-014 Input transfer SHALL occur when IN_VALID && IN_READY; output transfer when OUT_VALID && OUT_READY.
REQ-015 Internal state: accumulator ACC (WORD_W), slot pointer PTR (0..NSLOT-1), FSM {FILL, HOLD}.
REQ-016 FILL: IN_READY=1, OUT_VALID=0; each input transfer writes slot PTR of ACC and increments PTR.
REQ-017 FILL -> HOLD when transfer occurs with PTR==NSLOT-1 or IN_LAST=1; same edge SHALL load XOUT with ACC including the new field, OUT_COUNT=PTR+1, clear ACC to zero, PTR to 0.
REQ-018 Slots not written before an early close SHALL read as zero in XOUT.
REQ-019 HOLD: OUT_VALID=1; XOUT and OUT_COUNT SHALL stay stable until output transfer.
REQ-020 HOLD: IN_READY = OUT_READY (combinational); input transfer in the same cycle as output transfer SHALL write slot 0 of the new word (no bubble).
REQ-021 HOLD with output transfer: if the simultaneous input also closes the word (IN_LAST=1, or NSLOT==1), remain HOLD with new XOUT/OUT_COUNT=1; otherwise -> FILL with PTR=1 (or PTR=0 if no input transfer).
REQ-022 HOLD without output transfer: no input accepted, ACC/PTR unchanged.
REQ-023 IN_LAST SHALL be ignored when IN_VALID=0; IN_VALID with IN_READY=0 SHALL NOT alter any state.
REQ-024 Sustained throughput SHALL be one field per cycle when OUT_READY is held high; word latency from final field acceptance to OUT_VALID SHALL be 1 cycle.
REQ-025 OUT_COUNT arithmetic SHALL be unsigned, width 4; NSLOT > 15 not supported.

Reset
REQ-026 RST_N=0 at a rising edge SHALL force FSM=FILL, PTR=0, ACC=0, XOUT=0, OUT_COUNT=0, OUT_VALID=0; IN_READY SHALL read 1 from the first cycle after reset.
REQ-027 Reset mid-word or during HOLD SHALL discard the partial/held word; no output transfer for it afterwards.
REQ-028 Inputs during RST_N=0 SHALL be ignored.

Verification
REQ-029 Full word: OUT_READY=1, DIN=1,2,...,8 on consecutive cycles -> one cycle after the 8th, XOUT=32'h87654321, OUT_COUNT=8, OUT_VALID=1 for exactly 1 cycle.
REQ-030 Early close: DIN=4'hA, 4'hB (IN_LAST=1 on second) -> XOUT=32'h000000BA, OUT_COUNT=2.
REQ-031 Backpressure: word held with OUT_READY=0 for 5 cycles, IN_VALID=1 -> IN_READY=0, XOUT stable; on OUT_READY=1, DIN=4'h5 lands in slot 0 of next word.
REQ-032 Back-to-back single fields: IN_LAST=1 every cycle, DIN=3,7,9, OUT_READY=1 -> XOUT=3,7,9 on consecutive cycles, OUT_COUNT=1, OUT_VALID continuously high.
REQ-033 Reset mid-word: 3 fields accepted, RST_N=0 one cycle, then DIN=4'hF with IN_LAST -> XOUT=32'h0000000F, OUT_COUNT=1.
REQ-034 Round-trip: random fields packed, then each slot k sliced via (XOUT >> 4k)[3:0] SHALL equal the k-th accepted DIN.
